// File: rtl/mem_io_ctrl_if.sv
// CPU byte-bus and UART byte-stream signals of the memory/IO responder.
// master = CPU plus host side, slave = mem_io_ctrl.
interface mem_io_ctrl_if;
  logic [31:0] cpu_a;
  logic [7:0]  cpu_dout;
  logic        cpu_wr;
  logic [7:0]  cpu_din;
  logic        cpu_rdy;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  modport master (
    output cpu_a, cpu_dout, cpu_wr, rx_valid, rx_data, tx_ready,
    input  cpu_din, cpu_rdy, rx_ready, tx_valid, tx_data
  );

  modport slave (
    input  cpu_a, cpu_dout, cpu_wr, rx_valid, rx_data, tx_ready,
    output cpu_din, cpu_rdy, rx_ready, tx_valid, tx_data
  );
endinterface

// File: rtl/mem_io_ctrl.sv
// Responder for the CPU byte bus: byte RAM, UART RX/TX FIFOs at 0x30000,
// free-running cycle counter with snapshot and sticky halt at 0x30004.
module mem_io_ctrl #(
  parameter int RAM_AW  = 17,
  parameter int FIFO_AW = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  mem_io_ctrl_if.slave  bus,
  output logic          halted
);
  localparam int FIFO_DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] PTR_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW:0] PTR_WRAP = {1'b1, {FIFO_AW{1'b0}}};

  logic [7:0]         ram_mem [1 << RAM_AW];
  logic [7:0]         ram_q_reg;
  logic [7:0]         rx_mem  [FIFO_DEPTH];
  logic [7:0]         tx_mem  [FIFO_DEPTH];
  logic [FIFO_AW:0]   rx_wptr_reg, rx_rptr_reg, tx_wptr_reg, tx_rptr_reg;
  logic [31:0]        cnt_reg, snap_reg;
  logic [7:0]         io_q_reg;
  logic               rd_ram_sel_reg;
  logic               halted_reg;
  logic [7:0]         snap_byte [4];
  logic [7:0]         io_rd_data;

  logic               is_io, is_uart, is_cnt, is_cnt_base;
  logic [RAM_AW-1:0]  ram_idx;
  logic               rx_empty, rx_full, tx_empty, tx_full;
  logic               accept, rx_push, rx_pop, tx_push, tx_pop, ram_wr, ram_rd;
  logic               unused_addr_bits;

  assign unused_addr_bits = ^bus.cpu_a[31:18];

  assign is_io       = (bus.cpu_a[17:16] == 2'b11);
  assign is_uart     = is_io && (bus.cpu_a[15:0] == 16'h0000);
  assign is_cnt      = is_io && (bus.cpu_a[15:2] == 14'h0001);
  assign is_cnt_base = is_cnt && (bus.cpu_a[1:0] == 2'b00);
  assign ram_idx     = bus.cpu_a[RAM_AW-1:0];

  assign rx_empty = (rx_wptr_reg == rx_rptr_reg);
  assign rx_full  = ((rx_wptr_reg ^ rx_rptr_reg) == PTR_WRAP);
  assign tx_empty = (tx_wptr_reg == tx_rptr_reg);
  assign tx_full  = ((tx_wptr_reg ^ tx_rptr_reg) == PTR_WRAP);

  // Stall only on UART reads with nothing buffered or pushing writes into a full TX FIFO.
  assign bus.cpu_rdy = !rst_in
                     && !(is_uart && !bus.cpu_wr && rx_empty)
                     && !(is_uart && bus.cpu_wr && (bus.cpu_dout != 8'h00) && tx_full);
  assign accept = bus.cpu_rdy;

  assign rx_push = bus.rx_valid && !rx_full;
  assign rx_pop  = accept && is_uart && !bus.cpu_wr;
  assign tx_push = accept && is_uart && bus.cpu_wr && (bus.cpu_dout != 8'h00);
  assign tx_pop  = !tx_empty && bus.tx_ready;
  assign ram_wr  = accept && !is_io && bus.cpu_wr;
  assign ram_rd  = accept && !is_io && !bus.cpu_wr;

  assign bus.rx_ready = !rx_full;
  assign bus.tx_valid = !tx_empty;
  assign bus.tx_data  = tx_mem[tx_rptr_reg[FIFO_AW-1:0]];
  assign bus.cpu_din  = rd_ram_sel_reg ? ram_q_reg : io_q_reg;
  assign halted       = halted_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap_byte
      assign snap_byte[gi] = snap_reg[8*gi +: 8];
    end
  endgenerate

  always_comb begin
    io_rd_data = 8'h00;
    if (is_uart)
      io_rd_data = rx_mem[rx_rptr_reg[FIFO_AW-1:0]];
    else if (is_cnt_base)
      io_rd_data = cnt_reg[7:0];
    else if (is_cnt)
      io_rd_data = snap_byte[bus.cpu_a[1:0]];
  end

  // Storage arrays carry no reset so they map onto RAM primitives.
  always_ff @(posedge clk_in) begin
    if (ram_wr)
      ram_mem[ram_idx] <= bus.cpu_dout;
    if (ram_rd)
      ram_q_reg <= ram_mem[ram_idx];
    if (rx_push)
      rx_mem[rx_wptr_reg[FIFO_AW-1:0]] <= bus.rx_data;
    if (tx_push)
      tx_mem[tx_wptr_reg[FIFO_AW-1:0]] <= bus.cpu_dout;
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      rx_wptr_reg    <= '0;
      rx_rptr_reg    <= '0;
      tx_wptr_reg    <= '0;
      tx_rptr_reg    <= '0;
      cnt_reg        <= 32'h0;
      snap_reg       <= 32'h0;
      io_q_reg       <= 8'h00;
      rd_ram_sel_reg <= 1'b0;
      halted_reg     <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_reg <= rx_wptr_reg + PTR_ONE;
      if (rx_pop)  rx_rptr_reg <= rx_rptr_reg + PTR_ONE;
      if (tx_push) tx_wptr_reg <= tx_wptr_reg + PTR_ONE;
      if (tx_pop)  tx_rptr_reg <= tx_rptr_reg + PTR_ONE;

      if (!halted_reg)
        cnt_reg <= cnt_reg + 32'd1;
      if (accept && is_cnt_base && bus.cpu_wr)
        halted_reg <= 1'b1;
      // The base byte read freezes the whole word so bytes 1..3 stay coherent.
      if (accept && is_cnt_base && !bus.cpu_wr)
        snap_reg <= cnt_reg;

      if (accept && !bus.cpu_wr) begin
        rd_ram_sel_reg <= !is_io;
        if (is_io)
          io_q_reg <= io_rd_data;
      end
    end
  end
endmodule
